// File: rtl/tt_sweep_ctrl_if.sv
// Interface bundling the sweep controller's control, stimulus and result signals.
//   start          : sweep request (bench/board -> controller)
//   abcd           : vector driven to the function under test
//   f_in           : function output fed back from the block under test
//   busy           : sweep in progress
//   done           : one-cycle pulse at sweep end
//   pass           : err_cnt == 0, valid while/after done
//   err_cnt        : number of mismatching vectors (N_IN+1 bits, never wraps)
//   first_err_idx  : index of lowest mismatching vector
//   err_valid      : first_err_idx holds a real mismatch
//   tt_obs         : observed truth table (zero unless TT_CAPTURE_EN is defined)
// Modports: master = control/stimulus side, slave = tt_sweep_ctrl.
interface tt_sweep_ctrl_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic [N_IN-1:0]        abcd;
    logic                   f_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          err_cnt;
    logic [N_IN-1:0]        first_err_idx;
    logic                   err_valid;
    logic [(1<<N_IN)-1:0]   tt_obs;

    modport master (
        output start, f_in,
        input  abcd, busy, done, pass, err_cnt, first_err_idx, err_valid, tt_obs
    );

    modport slave (
        input  start, f_in,
        output abcd, busy, done, pass, err_cnt, first_err_idx, err_valid, tt_obs
    );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer for an N_IN-input combinational function.
// On start, drives every input vector 0 .. 2^N_IN-1 in ascending order, waits
// SETTLE_CYC cycles per vector, samples f_in and compares it with EXP_TT.
// Reports pass/fail, mismatch count and the first failing vector index.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : tt_sweep_ctrl_if.slave (start, abcd, f_in, busy, done, pass,
//            err_cnt, first_err_idx, err_valid, tt_obs)
// Optional feature macro: TT_CAPTURE_EN -- when defined, the observed truth
// table is captured into tt_obs; otherwise tt_obs is tied to zero.
module tt_sweep_ctrl #(
    parameter int                   N_IN       = 4,
    parameter int                   SETTLE_CYC = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TT     = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_sweep_ctrl_if.slave bus
);
    localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // With no settle time each vector goes straight to sampling.
    localparam state_t VEC_ENTRY = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   err_cnt_q;
    logic [N_IN-1:0] first_err_q;
    logic            err_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_cnt_q   <= '0;
                        err_valid_q <= 1'b0;
                        first_err_q <= '0;
                        pass_q      <= 1'b0;
                        idx         <= '0;
                        cnt         <= CNT_LOAD;
                        busy_q      <= 1'b1;
                        state       <= VEC_ENTRY;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.f_in != EXP_TT[idx]) begin
                        err_cnt_q <= err_cnt_q + (N_IN+1)'(1);
                        if (!err_valid_q) begin
                            first_err_q <= idx;
                            err_valid_q <= 1'b1;
                        end
                    end
                    if (idx == '1) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + N_IN'(1);
                        cnt   <= CNT_LOAD;
                        state <= VEC_ENTRY;
                    end
                end
                DONE: begin
                    // err_cnt already holds the final count here.
                    done_q <= 1'b1;
                    pass_q <= (err_cnt_q == '0);
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.abcd          = idx;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_idx = first_err_q;
    assign bus.err_valid     = err_valid_q;

`ifdef TT_CAPTURE_EN
    logic [(1<<N_IN)-1:0] tt_obs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_obs_q <= '0;
        end else if (state == IDLE && bus.start) begin
            tt_obs_q <= '0;
        end else if (state == SAMPLE) begin
            tt_obs_q[idx] <= bus.f_in;
        end
    end

    assign bus.tt_obs = tt_obs_q;
`else
    assign bus.tt_obs = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;
    localparam logic [15:0] EXP = 16'hA5C3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_sweep_ctrl_if #(.N_IN(4)) b0 ();
    tt_sweep_ctrl_if #(.N_IN(4)) b1 ();

    tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(2), .EXP_TT(EXP)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(0), .EXP_TT(EXP)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    // Emulated functions under test: F = tt[abcd].
    logic [15:0] tt0 = '0;
    logic [15:0] tt1 = '0;
    assign b0.f_in = tt0[b0.abcd];
    assign b1.f_in = tt1[b1.abcd];

    initial begin
        b0.start = 1'b0;
        b1.start = 1'b0;
    end

    int errors = 0;
    int checks = 0;

    // Selected-DUT view for the shared sweep task.
    bit          sel = 1'b0;
    logic [3:0]  s_abcd, s_first;
    logic        s_busy, s_done, s_pass, s_valid;
    logic [4:0]  s_cnt;
    logic [15:0] s_obs;
    always_comb begin
        s_abcd  = sel ? b1.abcd          : b0.abcd;
        s_busy  = sel ? b1.busy          : b0.busy;
        s_done  = sel ? b1.done          : b0.done;
        s_pass  = sel ? b1.pass          : b0.pass;
        s_cnt   = sel ? b1.err_cnt       : b0.err_cnt;
        s_first = sel ? b1.first_err_idx : b0.first_err_idx;
        s_valid = sel ? b1.err_valid     : b0.err_valid;
        s_obs   = sel ? b1.tt_obs        : b0.tt_obs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) b1.start = v; else b0.start = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_abcd"},  32'(s_abcd),  0);
        chk({tag, "_busy"},  32'(s_busy),  0);
        chk({tag, "_done"},  32'(s_done),  0);
        chk({tag, "_pass"},  32'(s_pass),  0);
        chk({tag, "_cnt"},   32'(s_cnt),   0);
        chk({tag, "_first"}, 32'(s_first), 0);
        chk({tag, "_valid"}, 32'(s_valid), 0);
        chk({tag, "_obs"},   32'(s_obs),   0);
    endtask

    // Runs one sweep on DUT s with function table tt. mid_k: cycle at which a
    // stray start pulse is issued; abort_k: cycle at which reset is applied.
    task automatic run_sweep(input bit s, input logic [15:0] tt,
                             input int mid_k, input int abort_k);
        int st, lat, ec, fi;
        logic [15:0] diff, exp_obs;
        sel = s;
        st  = s ? 0 : 2;
        lat = 16 * (st + 1) + 1;
        if (s) tt1 = tt; else tt0 = tt;
        diff = tt ^ EXP;
        ec = 0;
        fi = -1;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                ec++;
                if (fi < 0) fi = i;
            end
        end
        if (fi < 0) fi = 0;
`ifdef TT_CAPTURE_EN
        exp_obs = tt;
`else
        exp_obs = '0;
`endif
        @(negedge clk);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        // Now just past the edge that sampled start (cycle 0).
        for (int k = 0; k <= lat + 1; k++) begin
            int ea;
            set_start(s, 1'b0);
            ea = k / (st + 1);
            if (ea > 15) ea = 15;
            chk("abcd", 32'(s_abcd), 32'(ea));
            chk("busy", 32'(s_busy), 32'(k < lat));
            chk("done", 32'(s_done), 32'(k == lat));
            if (k >= lat) begin
                chk("pass",  32'(s_pass),  32'(ec == 0));
                chk("cnt",   32'(s_cnt),   32'(ec));
                chk("first", 32'(s_first), 32'(fi));
                chk("valid", 32'(s_valid), 32'(ec != 0));
                chk("obs",   32'(s_obs),   32'(exp_obs));
            end
            if (k == abort_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_reset("abort");
                rst_n = 1'b1;
                return;
            end
            if (k == mid_k) set_start(s, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1 chk_reset("rst0");
        sel = 1'b1;
        #1 chk_reset("rst1");
        rst_n = 1'b1;

        run_sweep(1'b0, EXP, -1, -1);                                 // matching table
        run_sweep(1'b0, EXP ^ 16'h0220, -1, -1);                      // bits 5, 9 wrong
        run_sweep(1'b0, ~EXP, -1, -1);                                // all vectors fail
        run_sweep(1'b0, 16'($urandom), 20, -1);                       // stray start mid-sweep
        run_sweep(1'b0, 16'($urandom), -1, 22);                       // reset at idx 7
        run_sweep(1'b0, 16'($urandom), -1, -1);                       // clean sweep after abort
        run_sweep(1'b1, EXP, -1, -1);                                 // zero settle time
        run_sweep(1'b1, 16'($urandom), -1, -1);
        for (int r = 0; r < 3; r++) begin
            run_sweep(1'b0, 16'($urandom), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
